// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : MIPS funct codes, FSM encoding and width helpers for alu_mdu.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [5:0] c_FN_SLL   = 6'b000000;
    localparam logic [5:0] c_FN_SRL   = 6'b000010;
    localparam logic [5:0] c_FN_SRA   = 6'b000011;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MTHI  = 6'b010001;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MTLO  = 6'b010011;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIV   = 6'b011010;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_XOR   = 6'b100110;
    localparam logic [5:0] c_FN_NOR   = 6'b100111;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_t;

    function automatic int shamt_width(input int n_bits);
        return $clog2(n_bits);
    endfunction

    // MULT, MULTU, DIV and DIVU share the 0110xx funct prefix.
    function automatic logic is_muldiv(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative shift-add multiplier / restoring divider, 1 bit/cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_iter
    import alu_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_is_div,
    input  logic              i_signed,
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [N_BITS-1:0] o_hi,
    output logic [N_BITS-1:0] o_lo
);

    localparam int            CW     = shamt_width(N_BITS);
    localparam logic [CW-1:0] c_LAST = CW'(N_BITS - 1);

    logic              r_busy;
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div0;
    logic [CW-1:0]     r_cnt;
    logic [N_BITS-1:0] r_opnd;
    logic [N_BITS-1:0] r_dividend;
    logic [N_BITS-1:0] r_upper;
    logic [N_BITS-1:0] r_lower;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [N_BITS-1:0] w_mag_a;
    logic [N_BITS-1:0] w_mag_b;

    logic [N_BITS:0]   w_sum;
    logic [N_BITS:0]   w_shift;
    logic [N_BITS:0]   w_diff;
    logic              w_fits;
    logic [N_BITS-1:0] w_upper_nx;
    logic [N_BITS-1:0] w_lower_nx;

    logic [2*N_BITS-1:0] w_prod;
    logic [2*N_BITS-1:0] w_prod_fix;

    assign w_a_neg = i_signed & i_a[N_BITS-1];
    assign w_b_neg = i_signed & i_b[N_BITS-1];
    assign w_mag_a = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_mag_b = w_b_neg ? (~i_b + 1'b1) : i_b;

    // Multiply: {r_upper, r_lower} holds {partial product, remaining multiplier}.
    // Divide:   {r_upper, r_lower} holds {partial remainder, dividend/quotient}.
    assign w_sum   = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_upper, r_lower[N_BITS-1]};
    assign w_diff  = w_shift - {1'b0, r_opnd};
    assign w_fits  = ~w_diff[N_BITS];

    always_comb begin
        w_upper_nx = w_sum[N_BITS:1];
        w_lower_nx = {w_sum[0], r_lower[N_BITS-1:1]};
        if (r_is_div) begin
            w_upper_nx = w_fits ? w_diff[N_BITS-1:0] : w_shift[N_BITS-1:0];
            w_lower_nx = {r_lower[N_BITS-2:0], w_fits};
        end
    end

    assign w_prod     = {w_upper_nx, w_lower_nx};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;

    // Result is formed from the final step's next-state so it is ready in the last busy cycle.
    always_comb begin
        o_hi = w_prod_fix[2*N_BITS-1:N_BITS];
        o_lo = w_prod_fix[N_BITS-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                o_hi = r_dividend;
                o_lo = '1;
            end else begin
                o_hi = r_neg_r ? (~w_upper_nx + 1'b1) : w_upper_nx;
                o_lo = r_neg_q ? (~w_lower_nx + 1'b1) : w_lower_nx;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == c_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_cnt      <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_upper    <= '0;
            r_lower    <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_is_div   <= i_is_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div0     <= (i_b == '0);
            r_cnt      <= '0;
            r_dividend <= i_a;
            r_upper    <= '0;
            r_opnd     <= i_is_div ? w_mag_b : w_mag_a;
            r_lower    <= i_is_div ? w_mag_a : w_mag_b;
        end else if (r_busy) begin
            r_upper <= w_upper_nx;
            r_lower <= w_lower_nx;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
// Module      : alu_mdu
// Description : MIPS-style ALU with HI/LO registers and iterative MUL/DIV unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mdu
    import alu_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter int SHW    = shamt_width(N_BITS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic [5:0]        i_op,
    output logic              o_valid,
    output logic [N_BITS-1:0] o_result,
    output logic              o_ovf,
    output logic [N_BITS-1:0] o_hi,
    output logic [N_BITS-1:0] o_lo
);

    localparam int MSB = N_BITS - 1;

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_valid;
    logic [N_BITS-1:0] r_result;
    logic              r_ovf;
    logic [N_BITS-1:0] r_hi;
    logic [N_BITS-1:0] r_lo;

    logic              w_accept;
    logic              w_md_start;
    logic              w_md_busy;
    logic              w_md_done;
    logic [N_BITS-1:0] w_md_hi;
    logic [N_BITS-1:0] w_md_lo;

    logic [SHW-1:0]    w_shamt;
    logic [N_BITS-1:0] w_sum;
    logic [N_BITS-1:0] w_diff;
    logic [N_BITS-1:0] w_alu_res;
    logic              w_alu_ovf;

    assign o_ready    = (r_state == S_IDLE);
    assign w_accept   = i_valid && o_ready;
    assign w_md_start = w_accept && is_muldiv(i_op);

    assign w_shamt = i_b[SHW-1:0];
    assign w_sum   = i_a + i_b;
    assign w_diff  = i_a - i_b;

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (i_op)
            c_FN_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            c_FN_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            c_FN_ADDU: w_alu_res = w_sum;
            c_FN_SUBU: w_alu_res = w_diff;
            c_FN_AND:  w_alu_res = i_a & i_b;
            c_FN_OR:   w_alu_res = i_a | i_b;
            c_FN_XOR:  w_alu_res = i_a ^ i_b;
            c_FN_NOR:  w_alu_res = ~(i_a | i_b);
            c_FN_SLT:  w_alu_res = {{(N_BITS-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            c_FN_SLTU: w_alu_res = {{(N_BITS-1){1'b0}}, i_a < i_b};
            c_FN_SLL:  w_alu_res = i_a << w_shamt;
            c_FN_SRL:  w_alu_res = i_a >> w_shamt;
            c_FN_SRA:  w_alu_res = $signed(i_a) >>> w_shamt;
            c_FN_MFHI: w_alu_res = r_hi;
            c_FN_MFLO: w_alu_res = r_lo;
            c_FN_MTHI: w_alu_res = i_a;
            c_FN_MTLO: w_alu_res = i_a;
            default:   w_alu_res = '0;
        endcase
    end

    muldiv_iter #(
        .N_BITS (N_BITS)
    ) u_muldiv (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_md_start),
        .i_is_div (i_op[1]),
        .i_signed (~i_op[0]),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_md_start) begin
                    w_state_nx = i_op[1] ? S_DIV : S_MUL;
                end
            end
            // Falling back on !busy keeps the FSM from ever stranding outside IDLE.
            S_MUL, S_DIV: begin
                if (w_md_done || !w_md_busy) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            if (w_accept && !w_md_start) begin
                r_valid  <= 1'b1;
                r_result <= w_alu_res;
                r_ovf    <= w_alu_ovf;
                if (i_op == c_FN_MTHI) begin
                    r_hi <= i_a;
                end
                if (i_op == c_FN_MTLO) begin
                    r_lo <= i_a;
                end
            end else if (w_md_done) begin
                r_valid  <= 1'b1;
                r_result <= w_md_lo;
                r_hi     <= w_md_hi;
                r_lo     <= w_md_lo;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_ovf    = r_ovf;
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module      : tb_alu_mdu
// Description : Self-checking bench for alu_mdu (vector table, model, corners).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;
    import alu_pkg::*;

    localparam int     N    = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [5:0]    op = '0;
    logic          o_valid;
    logic [N-1:0]  res;
    logic          ovf;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [N-1:0]  m_hi = '0;
    logic [N-1:0]  m_lo = '0;

    typedef struct {
        logic [5:0]   f;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] er;
        logic         eo;
        string        tag;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    alu_mdu #(.N_BITS(N)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (ready),
        .i_a      (a),
        .i_b      (b),
        .i_op     (op),
        .o_valid  (o_valid),
        .o_result (res),
        .o_ovf    (ovf),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the instruction semantics, using 64-bit integer arithmetic.
    task automatic model(input logic [5:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic [N-1:0] hin, input logic [N-1:0] lin,
                         output logic [N-1:0] r, output logic o,
                         output logic [N-1:0] hout, output logic [N-1:0] lout, output logic md);
        int          ix;
        int          iy;
        longint      s;
        logic [63:0] p;
        int unsigned sh;
        ix = x; iy = y; sh = y % 32;
        r = '0; o = 1'b0; hout = hin; lout = lin; md = 1'b0;
        case (f)
            6'b100000: begin s = longint'(ix) + longint'(iy); r = s[31:0]; o = (s > MAXI) || (s < MINI); end
            6'b100010: begin s = longint'(ix) - longint'(iy); r = s[31:0]; o = (s > MAXI) || (s < MINI); end
            6'b100001: r = x + y;
            6'b100011: r = x - y;
            6'b100100: r = x & y;
            6'b100101: r = x | y;
            6'b100110: r = x ^ y;
            6'b100111: r = ~(x | y);
            6'b101010: r = (ix < iy) ? 32'd1 : 32'd0;
            6'b101011: r = (x < y) ? 32'd1 : 32'd0;
            6'b000000: begin p = {32'd0, x} * (64'd1 << sh); r = p[31:0]; end
            6'b000010: r = x / (32'd1 << sh);
            6'b000011: r = ix >>> sh;
            6'b010000: r = hin;
            6'b010010: r = lin;
            6'b010001: begin r = x; hout = x; end
            6'b010011: begin r = x; lout = x; end
            6'b011000: begin md = 1'b1; s = longint'(ix) * longint'(iy); hout = s[63:32]; lout = s[31:0]; end
            6'b011001: begin md = 1'b1; p = {32'd0, x} * {32'd0, y}; hout = p[63:32]; lout = p[31:0]; end
            6'b011010: begin
                md = 1'b1;
                if (y == 0) begin lout = '1; hout = x; end
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin lout = x; hout = '0; end
                else begin lout = ix / iy; hout = ix % iy; end
            end
            6'b011011: begin
                md = 1'b1;
                if (y == 0) begin lout = '1; hout = x; end
                else begin lout = x / y; hout = x % y; end
            end
            default: r = '0;
        endcase
        if (md) r = lout;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_md(input logic [5:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] eh, input logic [N-1:0] el, input string tag);
        logic [N-1:0] old_h;
        logic [N-1:0] old_l;
        bit           busy_ok;
        int           lat;
        old_h = m_hi; old_l = m_lo; busy_ok = 1'b1;
        op = f; a = x; b = y; i_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!o_valid && lat <= N + 4) begin
            if (ready || hi !== old_h || lo !== old_l) busy_ok = 1'b0;
            op = c_FN_ADD; a = $urandom; b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        i_valid = 1'b0;
        chk({tag, " busy"}, 128'(busy_ok), 128'd1);
        chk({tag, " latency"}, 128'(lat), 128'(N + 1));
        chk({tag, " result"}, {ready, ovf, res, hi, lo}, {1'b1, 1'b0, el, eh, el});
        m_hi = eh; m_lo = el;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                          input string tag);
        logic [N-1:0] er;
        logic [N-1:0] eh;
        logic [N-1:0] el;
        logic         eo;
        logic         md;
        model(f, x, y, m_hi, m_lo, er, eo, eh, el, md);
        if (md) begin
            run_md(f, x, y, eh, el, tag);
        end else begin
            op = f; a = x; b = y; i_valid = 1'b1;
            @(posedge clk); #1;
            i_valid = 1'b0;
            chk(tag, {o_valid, ovf, res, hi, lo}, {1'b1, eo, er, eh, el});
            m_hi = eh; m_lo = el;
        end
    endtask

    function automatic logic [N-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h7FFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] singles [20];
        logic [5:0] mds     [4];
        bit         seen;

        singles = '{c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND, c_FN_OR, c_FN_XOR,
                    c_FN_NOR, c_FN_SLT, c_FN_SLTU, c_FN_SLL, c_FN_SRL, c_FN_SRA, c_FN_MFHI,
                    c_FN_MFLO, c_FN_MTHI, c_FN_MTLO, 6'b111111, 6'b000001, 6'b101000};
        mds = '{c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU};

        tbl.push_back('{c_FN_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, "add_ovf"});
        tbl.push_back('{c_FN_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, "addu_noovf"});
        tbl.push_back('{c_FN_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "add_wrap"});
        tbl.push_back('{c_FN_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, "sub_ovf"});
        tbl.push_back('{c_FN_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, "sub_ovf2"});
        tbl.push_back('{c_FN_SUBU, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, "subu"});
        tbl.push_back('{c_FN_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, "and"});
        tbl.push_back('{c_FN_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, "or"});
        tbl.push_back('{c_FN_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, "xor"});
        tbl.push_back('{c_FN_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, "nor"});
        tbl.push_back('{c_FN_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, "slt"});
        tbl.push_back('{c_FN_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "sltu"});
        tbl.push_back('{c_FN_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, "sll_hi_ign"});
        tbl.push_back('{c_FN_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, "sra"});
        tbl.push_back('{c_FN_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, "srl"});
        tbl.push_back('{c_FN_SRA,  32'h40000000, 32'h0000001F, 32'h00000000, 1'b0, "sra_pos"});
        tbl.push_back('{6'b111111, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0, "unknown"});

        #12;
        chk("reset_state", {ready, o_valid, ovf, res, hi, lo}, {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table issued back to back, one request per cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            op = tbl[i].f; a = tbl[i].x; b = tbl[i].y; i_valid = 1'b1;
            @(posedge clk); #1;
            chk(tbl[i].tag, {o_valid, ovf, res}, {1'b1, tbl[i].eo, tbl[i].er});
        end
        i_valid = 1'b0;
        chk("hilo_untouched", {hi, lo}, {32'h0, 32'h0});

        run_md(c_FN_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
        run_md(c_FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_md(c_FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_md(c_FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_zero");
        run_md(c_FN_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_zero");
        run_md(c_FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minneg");
        run_md(c_FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu");

        // Move to HI, read it back, then add: three consecutive results.
        run_op(c_FN_MTHI, 32'h00001234, 32'h0, "b2b_mthi");
        run_op(c_FN_MFHI, 32'h0, 32'h0, "b2b_mfhi");
        chk("b2b_mfhi_val", res, 32'h00001234);
        run_op(c_FN_ADD, 32'h00000100, 32'h00000023, "b2b_add");
        chk("b2b_add_val", res, 32'h00000123);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0)
                run_op(mds[$urandom_range(0, 3)], pick_operand(), pick_operand(), "rand_md");
            else
                run_op(singles[$urandom_range(0, 19)], pick_operand(), pick_operand(), "rand_op");
        end

        // Abort a DIVU ten cycles in with reset.
        op = c_FN_DIVU; a = 32'd1000; b = 32'd3; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_reset", {ready, o_valid, ovf, res, hi, lo}, {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < N + 5; k++) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 128'(seen), 128'd0);
        chk("abort_after", {ready, hi, lo}, {1'b1, 32'h0, 32'h0});
        m_hi = '0; m_lo = '0;
        run_op(c_FN_MFLO, 32'h0, 32'h0, "post_abort_mflo");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
